// File: rtl/usb_gpx_conditioner.sv
// Synchroniser, glitch filter and edge/event capture for the asynchronous MAX3421E GPX pin.
// Define USB_GPX_GLITCH_STATS_EN to add the glitch_count output (rejected-glitch counter).
module usb_gpx_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gpx_pin,
  input  logic [1:0]       edge_sel,
  input  logic             evt_clear,
  output logic             gpx_level,
  output logic             gpx_rise,
  output logic             gpx_fall,
  output logic             evt_pending,
  output logic [CNT_W-1:0] evt_count
`ifdef USB_GPX_GLITCH_STATS_EN
  ,
  output logic [CNT_W-1:0] glitch_count
`endif
);

  localparam int FC_W = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FC_W-1:0]        fc;
  logic                   qualify;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], gpx_pin};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The level only flips after FILTER_CYCLES consecutive disagreeing samples;
  // the edge pulses are registered alongside it so they line up with the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      fc        <= '0;
      gpx_level <= 1'b0;
      gpx_rise  <= 1'b0;
      gpx_fall  <= 1'b0;
    end else begin
      gpx_rise <= 1'b0;
      gpx_fall <= 1'b0;
      if (s == gpx_level) begin
        fc <= '0;
      end else if (fc == FC_LAST) begin
        fc        <= '0;
        gpx_level <= s;
        gpx_rise  <= s;
        gpx_fall  <= ~s;
      end else begin
        fc <= fc + FC_W'(1);
      end
    end
  end

  always_comb begin
    qualify = 1'b0;
    case (edge_sel)
      2'b00:   qualify = gpx_rise;
      2'b01:   qualify = gpx_fall;
      2'b10:   qualify = gpx_rise | gpx_fall;
      default: qualify = 1'b0;
    endcase
  end

  // A qualifying edge beats a simultaneous clear, so the clear restarts the count at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_pending <= 1'b0;
      evt_count   <= '0;
    end else if (qualify) begin
      evt_pending <= 1'b1;
      if (evt_clear)              evt_count <= CNT_W'(1);
      else if (evt_count != '1)   evt_count <= evt_count + CNT_W'(1);
    end else if (evt_clear) begin
      evt_pending <= 1'b0;
      evt_count   <= '0;
    end
  end

`ifdef USB_GPX_GLITCH_STATS_EN
  logic glitch_reject;

  assign glitch_reject = (s == gpx_level) && (fc != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_count <= '0;
    end else if (evt_clear) begin
      glitch_count <= glitch_reject ? CNT_W'(1) : '0;
    end else if (glitch_reject && (glitch_count != '1)) begin
      glitch_count <= glitch_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Randomised and directed bench for usb_gpx_conditioner against a run-length reference model.
module tb_usb_gpx_conditioner;

  localparam int S = 2;
  localparam int F = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       gpx_pin;
  logic [1:0] edge_sel;
  logic       evt_clear;

  logic       gpx_level, gpx_rise, gpx_fall, evt_pending;
  logic [7:0] evt_count;
  logic       gpx_level2, gpx_rise2, gpx_fall2, evt_pending2;
  logic [1:0] evt_count2;
`ifdef USB_GPX_GLITCH_STATS_EN
  logic [7:0] glitch_count;
  logic [1:0] glitch_count2;
`endif

  int total = 0;
  int bad   = 0;
  bit check_en = 0;
  int rise_seen = 0;
  int fall_seen = 0;

  usb_gpx_conditioner #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .gpx_pin(gpx_pin), .edge_sel(edge_sel), .evt_clear(evt_clear),
    .gpx_level(gpx_level), .gpx_rise(gpx_rise), .gpx_fall(gpx_fall),
    .evt_pending(evt_pending), .evt_count(evt_count)
`ifdef USB_GPX_GLITCH_STATS_EN
    , .glitch_count(glitch_count)
`endif
  );

  usb_gpx_conditioner #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .gpx_pin(gpx_pin), .edge_sel(edge_sel), .evt_clear(evt_clear),
    .gpx_level(gpx_level2), .gpx_rise(gpx_rise2), .gpx_fall(gpx_fall2),
    .evt_pending(evt_pending2), .evt_count(evt_count2)
`ifdef USB_GPX_GLITCH_STATS_EN
    , .glitch_count(glitch_count2)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the synchronised pin is a plain delay line, and the level flips once
  // a run of F consecutive samples disagrees with it.
  logic [S-1:0] m_pipe;
  int m_run, m_cnt, m_cnt2, m_gc, m_gc2;
  bit m_level, m_rise, m_fall, m_pend;
  bit ms, mq, mrej;

  always @(posedge clk) begin
    if (reset) begin
      m_pipe = '0; m_run = 0; m_level = 0; m_rise = 0; m_fall = 0;
      m_pend = 0; m_cnt = 0; m_cnt2 = 0; m_gc = 0; m_gc2 = 0;
    end else begin
      ms = m_pipe[S-1];
      mq = (edge_sel == 2'd0 && m_rise) || (edge_sel == 2'd1 && m_fall) ||
           (edge_sel == 2'd2 && (m_rise || m_fall));
      if (mq) begin
        m_pend = 1;
        m_cnt  = evt_clear ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        m_cnt2 = evt_clear ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
      end else if (evt_clear) begin
        m_pend = 0; m_cnt = 0; m_cnt2 = 0;
      end
      mrej = (ms == m_level) && (m_run != 0);
      if (evt_clear) begin
        m_gc = mrej ? 1 : 0; m_gc2 = m_gc;
      end else if (mrej) begin
        m_gc  = (m_gc < 255) ? m_gc + 1 : 255;
        m_gc2 = (m_gc2 < 3) ? m_gc2 + 1 : 3;
      end
      m_rise = 0; m_fall = 0;
      if (ms != m_level) begin
        m_run++;
        if (m_run == F) begin
          m_level = ms; m_run = 0; m_rise = ms; m_fall = !ms;
        end
      end else begin
        m_run = 0;
      end
      m_pipe = {m_pipe[S-2:0], gpx_pin};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pin, input logic [1:0] sel, input logic clr, input int cycles);
    gpx_pin = pin; edge_sel = sel; evt_clear = clr;
    repeat (cycles) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (gpx_rise) rise_seen++;
    if (gpx_fall) fall_seen++;
    if (check_en) begin
      checkOutput("level", gpx_level, m_level);
      checkOutput("rise", gpx_rise, m_rise);
      checkOutput("fall", gpx_fall, m_fall);
      checkOutput("pending", evt_pending, m_pend);
      checkOutput("count", evt_count, m_cnt);
      checkOutput("level2", gpx_level2, m_level);
      checkOutput("pending2", evt_pending2, m_pend);
      checkOutput("count2", evt_count2, m_cnt2);
      checkOutput("both_pulses", gpx_rise & gpx_fall, 0);
`ifdef USB_GPX_GLITCH_STATS_EN
      checkOutput("glitch", glitch_count, m_gc);
      checkOutput("glitch2", glitch_count2, m_gc2);
`endif
    end
  end

  // Counts negedges after reset release until the level goes high, bounded at 20.
  task automatic waitLevelHigh(output int n);
    n = 0;
    while (!gpx_level && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n, rb, fb;

  initial begin
    reset = 1; gpx_pin = 1; edge_sel = 2'b00; evt_clear = 0;
    @(posedge clk); #1 check_en = 1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    $display("[TB] reset with pin high");
    checkOutput("reset_level", gpx_level, 0);
    checkOutput("reset_count", evt_count, 0);
    rb = rise_seen;
    reset = 0;
    waitLevelHigh(n);
    checkOutput("reset_latency_ok", (n >= 5 && n <= 7), 1);
    repeat (3) @(negedge clk);
    checkOutput("reset_rise_pulses", rise_seen - rb, 1);

    $display("[TB] short glitch rejected");
    applyStimulus(0, 2'b00, 0, 12);
    checkOutput("low_level", gpx_level, 0);
    rb = rise_seen; fb = fall_seen;
    applyStimulus(1, 2'b00, 0, 3);
    applyStimulus(0, 2'b00, 0, 10);
    checkOutput("glitch_level", gpx_level, 0);
    checkOutput("glitch_pulses", (rise_seen - rb) + (fall_seen - fb), 0);
`ifdef USB_GPX_GLITCH_STATS_EN
    checkOutput("glitch_count_lit", glitch_count, 1);
`endif

    $display("[TB] both edges, three pulses");
    applyStimulus(0, 2'b10, 1, 1);
    rb = rise_seen; fb = fall_seen;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b10, 0, 10);
      applyStimulus(0, 2'b10, 0, 10);
    end
    checkOutput("both_rises", rise_seen - rb, 3);
    checkOutput("both_falls", fall_seen - fb, 3);
    checkOutput("both_count", evt_count, 6);
    checkOutput("both_pending", evt_pending, 1);
    checkOutput("both_count_sat2", evt_count2, 3);

    $display("[TB] clear coinciding with a rising edge");
    applyStimulus(0, 2'b00, 1, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 2'b00, 0, 10);
      applyStimulus(0, 2'b00, 0, 10);
    end
    checkOutput("five_count", evt_count, 5);
    checkOutput("five_count_sat2", evt_count2, 3);
    applyStimulus(1, 2'b00, 0, 0);
    n = 0;
    while (!gpx_rise && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rise_found", gpx_rise, 1);
    applyStimulus(1, 2'b00, 1, 1);
    evt_clear = 0;
    checkOutput("clr_edge_pending", evt_pending, 1);
    checkOutput("clr_edge_count", evt_count, 1);
    checkOutput("clr_edge_count2", evt_count2, 1);
    applyStimulus(1, 2'b00, 1, 1);
    evt_clear = 0;
    checkOutput("clr_alone_count", evt_count, 0);
    checkOutput("clr_alone_pending", evt_pending, 0);
    checkOutput("clr_alone_count2", evt_count2, 0);

    $display("[TB] reset in the middle of a filter run");
    applyStimulus(0, 2'b00, 0, 12);
    applyStimulus(1, 2'b00, 0, 4);
    reset = 1;
    repeat (2) @(negedge clk);
    checkOutput("midreset_level", gpx_level, 0);
    reset = 0;
    waitLevelHigh(n);
    checkOutput("midreset_latency_ok", (n >= 5 && n <= 7), 1);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 400; i++) begin
      int len;
      logic p, c;
      logic [1:0] sl;
      len = $urandom_range(1, 8);
      p   = 1'($urandom_range(0, 1));
      sl  = 2'($urandom_range(0, 3));
      c   = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 59) == 0);
      applyStimulus(p, sl, c, 1);
      reset = 0;
      if (len > 1) applyStimulus(p, sl, 0, len - 1);
    end
    applyStimulus(0, 2'b00, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_gpx_conditioner.md
Name: usb_gpx_conditioner

Overview:
- Input conditioner for the asynchronous MAX3421E GPX pin, placed directly upstream of the GPX PIO.
- Synchronises and glitch-filters the pin, then drives the clean level into the PIO `in_port`.
- Detects edges on the clean level and holds a sticky event flag with an event counter, so firmware can catch short GPX activity between PIO polls.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops; minimum 2.
- FILTER_CYCLES, 16: consecutive synchronised samples that must disagree with the current level before it flips; minimum 1, where 1 means no filtering.
- CNT_W, 8: width of `evt_count`.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- gpx_pin  in  1  raw asynchronous GPX pin.
- edge_sel  in  2  qualifying edge: 00 rising, 01 falling, 10 both, 11 none.
- evt_clear  in  1  single-cycle pulse; clears `evt_pending` and `evt_count`.
- gpx_level  out  1  filtered level; feeds PIO `in_port`.
- gpx_rise  out  1  one-cycle pulse on a filtered rising edge.
- gpx_fall  out  1  one-cycle pulse on a filtered falling edge.
- evt_pending  out  1  sticky flag; set by any qualifying edge.
- evt_count  out  CNT_W  number of qualifying edges since the last clear.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. All state updates on the rising clk edge.
- Reset values: synchroniser flops 0, filter counter 0, `gpx_level` 0, `gpx_rise` 0, `gpx_fall` 0, `evt_pending` 0, `evt_count` 0.
- Reset during a filter run discards the partial count. The first post-reset sample starts from count 0.
- Synchroniser: SYNC_STAGES-deep chain; the last stage is `s`.
- Filter counter `fc` (width clog2(FILTER_CYCLES)+1):
  - If `s` equals `gpx_level`: `fc` <= 0.
  - Otherwise, if `fc` equals FILTER_CYCLES-1: `gpx_level` <= `s` and `fc` <= 0.
  - Otherwise: `fc` <= `fc`+1.
- Glitch rejection: any disagreement lasting fewer than FILTER_CYCLES consecutive samples leaves `gpx_level` unchanged.
- Latency: from a pin transition to `gpx_level` is SYNC_STAGES+FILTER_CYCLES cycles, with +1 cycle of asynchronous sampling uncertainty.
- Edge pulses:
  - Registered. `gpx_rise` or `gpx_fall` is high for exactly the first cycle in which `gpx_level` shows its new value.
  - They are never both high in the same cycle.
- Qualifying edge: `gpx_rise` when `edge_sel`=00; `gpx_fall` when 01; either when 10; never when 11. Qualification uses `edge_sel` as sampled in the pulse cycle.
- On a qualifying edge, in the cycle after the pulse: `evt_pending` <= 1 and `evt_count` <= `evt_count`+1.
- `evt_count` saturates at 2^CNT_W-1 and does not wrap.
- `evt_clear` alone: `evt_pending` <= 0 and `evt_count` <= 0 on the next edge.
- `evt_clear` in the same cycle as a qualifying edge: the event wins, giving `evt_pending`=1 and `evt_count`=1.
- `evt_clear` while `gpx_level` is steady has no effect on the level path.
- Changing `edge_sel` never creates or removes an edge by itself. It only affects how later pulses are qualified.

Optional Feature:
- Macro: USB_GPX_GLITCH_STATS_EN.
- When defined:
  - Adds output `glitch_count` (CNT_W bits, reset 0).
  - It increments, saturating, each cycle `fc` returns to 0 because `s` came back to `gpx_level` while `fc` was nonzero, i.e. each rejected glitch.
  - It is cleared by `evt_clear`; a clear and an increment in the same cycle give 1.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan (FILTER_CYCLES=4, SYNC_STAGES=2, CNT_W=8 unless stated):
- Reset held 3 cycles with `gpx_pin`=1 -> all outputs 0 during reset. `gpx_level` rises 6 cycles (±1) after reset deasserts, with a single `gpx_rise` pulse.
- `gpx_pin` high for 3 cycles, then low -> `gpx_level` stays 0 and there are no pulses. With the macro, `glitch_count`=1.
- `edge_sel`=10, pin pulsed high 10 cycles then low 10 cycles, repeated 3 times -> 3 `gpx_rise` and 3 `gpx_fall` pulses; `evt_count`=6; `evt_pending`=1.
- `edge_sel`=00 and `evt_clear` asserted in the exact cycle `gpx_rise` is high, with count 5 beforehand -> next cycle `evt_pending`=1 and `evt_count`=1.
- CNT_W=2, `edge_sel`=00, 5 rising edges -> `evt_count` stops at 3. `evt_clear` -> 0 on the next cycle.
- Reset asserted mid-filter (`fc`=2, pin high), then released with the pin still high -> `gpx_level` rises 6 cycles (±1) after release, not earlier.
